cam_msg_sched: RTL and testbench
================================

CAM_MSG_SCHED -- requirements
Module: cam_msg_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, CAM entry/tag width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, CAM address width.
REQ-003 SHALL have parameter DESC_DEPTH, default 4, message-descriptor queue depth (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 16, max cycles waited for a CAM result.
REQ-005 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports store_start_i / store_end_i  in  1  message start/end strobes from the write controller.
REQ-008 SHALL have ports start_addr_i / end_addr_i  in  ADDR_WIDTH  message boundary addresses, valid with their strobes.
REQ-009 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_tag_i in DATA_WIDTH, req_last_i in 1: tag-lookup request; last marks the final lookup of a message.
REQ-010 SHALL have ports cam_search_o out 1, cam_search_data_o out DATA_WIDTH, cam_start_o / cam_end_o out ADDR_WIDTH: CAM search command and window.
REQ-011 SHALL have ports cam_done_i in 1, cam_hit_i in 1, cam_index_i in ADDR_WIDTH: CAM result.
REQ-012 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_hit_o out 1, rsp_index_o out ADDR_WIDTH, rsp_timeout_o out 1: lookup response.
REQ-013 SHALL have outputs msg_avail_o, desc_full_o, overflow_o, proto_err_o, each 1 bit.

Function
REQ-014 store_start_i SHALL latch start_addr_i into a pending-start register and set a pending flag; a second start before an end overwrites it.
REQ-015 store_end_i with pending flag set SHALL push {pending start, end_addr_i} into the descriptor queue and clear the flag; without a pending start it SHALL be ignored and set proto_err_o (sticky).
REQ-016 Same-cycle store_start_i and store_end_i SHALL be treated as end first, then start.
REQ-017 A push into a full queue SHALL be dropped and set overflow_o (sticky), unless a pop occurs the same cycle, in which case it is accepted.
REQ-018 desc_full_o SHALL equal queue count == DESC_DEPTH; msg_avail_o SHALL equal count != 0.
REQ-019 FSM states SHALL be IDLE, READY, SEARCH, WAIT, RESP.
REQ-020 IDLE -> READY when the queue is non-empty; the head descriptor drives cam_start_o/cam_end_o in all non-IDLE states.
REQ-021 req_ready_o SHALL be 1 only in READY; a handshake (req_valid_i & req_ready_o) registers tag and last flag and moves to SEARCH.
REQ-022 SEARCH SHALL assert cam_search_o for exactly one cycle with cam_search_data_o = registered tag, then move to WAIT.
REQ-023 WAIT SHALL count cycles; cam_done_i registers hit/index and moves to RESP; count reaching TIMEOUT with no cam_done_i SHALL move to RESP with rsp_hit_o=0, rsp_timeout_o=1.
REQ-024 cam_done_i outside WAIT SHALL be ignored.
REQ-025 RESP SHALL hold rsp_valid_o and payload stable until rsp_ready_i; on acceptance, last=1 pops the descriptor and goes to IDLE, last=0 returns to READY.
REQ-026 Windows with end < start (wrap-around) SHALL be passed to the CAM unchanged.
REQ-027 Request-to-response latency SHALL be 3 cycles when cam_done_i arrives in the first WAIT cycle.

Reset
REQ-028 rst SHALL force IDLE, empty queue, clear pending flag, clear overflow_o and proto_err_o, and drive all outputs to 0, including mid-transaction.

Structure
REQ-029 Package cam_pkg SHALL hold the FSM state enum, the descriptor struct {start, end}, and default width constants.
REQ-030 The descriptor queue SHALL be a sub-module cam_desc_fifo (push/pop/full/empty/count).

Verification
REQ-031 start@3, end@9, tag 0x38 req last=1, cam_done hit idx 5 one cycle after search -> cam_start_o=3, cam_end_o=9, rsp hit=1 idx=5 three cycles after handshake, queue empties.
REQ-032 Five complete messages with no lookups, DESC_DEPTH=4 -> desc_full_o=1 after 4th, overflow_o=1 after 5th, first 4 descriptors intact.
REQ-033 No cam_done_i after search -> rsp_valid_o with timeout=1, hit=0 after exactly TIMEOUT WAIT cycles.
REQ-034 store_end_i with no prior start -> proto_err_o=1, no push; start@30, end@2 -> window 30..2 passed unchanged.
REQ-035 rsp_ready_i held low 5 cycles, then rst pulsed in WAIT of next lookup -> response stable during stall; after rst all outputs 0, state IDLE.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default widths for the CAM message scheduler.
package cam_pkg;

  localparam int unsigned CAM_DATA_W     = 32;
  localparam int unsigned CAM_ADDR_W     = 5;
  localparam int unsigned CAM_DESC_DEPTH = 4;
  localparam int unsigned CAM_TIMEOUT    = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    SEARCH = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // One stored message window; end may be below start (wrap-around).
  typedef struct packed {
    logic [CAM_ADDR_W-1:0] start_addr;
    logic [CAM_ADDR_W-1:0] end_addr;
  } desc_t;

endpackage

// File: rtl/cam_msg_sched_if.sv
// Lookup request, CAM command/result and lookup response signals.
interface cam_msg_sched_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [DATA_WIDTH-1:0] req_tag_i;
  logic                  req_last_i;

  logic                  cam_search_o;
  logic [DATA_WIDTH-1:0] cam_search_data_o;
  logic [ADDR_WIDTH-1:0] cam_start_o;
  logic [ADDR_WIDTH-1:0] cam_end_o;
  logic                  cam_done_i;
  logic                  cam_hit_i;
  logic [ADDR_WIDTH-1:0] cam_index_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_index_o;
  logic                  rsp_timeout_o;

  // Scheduler side
  modport slave (
    input  req_valid_i, req_tag_i, req_last_i,
    output req_ready_o,
    output cam_search_o, cam_search_data_o, cam_start_o, cam_end_o,
    input  cam_done_i, cam_hit_i, cam_index_i,
    output rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_timeout_o,
    input  rsp_ready_i
  );

  // Requester / CAM model side
  modport master (
    output req_valid_i, req_tag_i, req_last_i,
    input  req_ready_o,
    input  cam_search_o, cam_search_data_o, cam_start_o, cam_end_o,
    output cam_done_i, cam_hit_i, cam_index_i,
    input  rsp_valid_o, rsp_hit_o, rsp_index_o, rsp_timeout_o,
    output rsp_ready_i
  );

endinterface

// File: rtl/cam_desc_fifo.sv
// Message-descriptor queue; a push into a full queue is accepted only alongside a pop.
module cam_desc_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok_c, pop_ok_c;

  // Accepted push/pop and next occupancy
  always_comb begin
    pop_ok_c  = pop_i & ~empty_q;
    push_ok_c = push_i & (~full_q | pop_ok_c);
    count_d   = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
  end

  // Pointers, occupancy and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array; contents only read while non-empty
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/cam_msg_sched.sv
// Collects message windows from the write controller and serializes tag lookups against the CAM.
module cam_msg_sched
  import cam_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CAM_DATA_W,
  parameter int unsigned ADDR_WIDTH = CAM_ADDR_W,
  parameter int unsigned DESC_DEPTH = CAM_DESC_DEPTH,
  parameter int unsigned TIMEOUT    = CAM_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_start_i,
  input  logic                  store_end_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
  cam_msg_sched_if.slave        bus,
  output logic                  msg_avail_o,
  output logic                  desc_full_o,
  output logic                  overflow_o,
  output logic                  proto_err_o
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned DESC_W = 2 * ADDR_WIDTH;
  localparam int unsigned CNT_W  = $clog2(DESC_DEPTH) + 1;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pstart_q, pstart_d;
  logic                  overflow_q, overflow_d;
  logic                  proto_err_q, proto_err_d;
  logic [DATA_WIDTH-1:0] tag_q, tag_d;
  logic                  last_q, last_d;
  logic                  hit_q, hit_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  tmo_q, tmo_d;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, cam_search_q, rsp_valid_q;
  logic [ADDR_WIDTH-1:0] cam_start_q, cam_end_q;
  logic                  push_c, pop_c;
  logic [DESC_W-1:0]     head;
  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  cam_desc_fifo #(.WIDTH(DESC_W), .DEPTH(DESC_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i ({pstart_q, end_addr_i}),
    .pop_i       (pop_c),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Start/end strobe tracking: the end is applied before a same-cycle start
  always_comb begin
    pend_d      = pend_q;
    pstart_d    = pstart_q;
    push_c      = store_end_i & pend_q;
    proto_err_d = proto_err_q | (store_end_i & ~pend_q);
    if (push_c) pend_d = 1'b0;
    if (store_start_i) begin
      pend_d   = 1'b1;
      pstart_d = start_addr_i;
    end
    overflow_d = overflow_q | (push_c & fifo_full & ~pop_c);
  end

  // Lookup FSM next state and response payload
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    last_d  = last_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE:   if (!fifo_empty) state_d = READY;
      READY:  if (bus.req_valid_i) begin
                tag_d   = bus.req_tag_i;
                last_d  = bus.req_last_i;
                state_d = SEARCH;
              end
      SEARCH: begin
                cnt_d   = '0;
                state_d = WAIT;
              end
      WAIT:   if (bus.cam_done_i) begin
                hit_d   = bus.cam_hit_i;
                idx_d   = bus.cam_index_i;
                tmo_d   = 1'b0;
                state_d = RESP;
              end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                hit_d   = 1'b0;
                idx_d   = '0;
                tmo_d   = 1'b1;
                state_d = RESP;
              end else begin
                cnt_d = cnt_q + TMO_W'(1);
              end
      RESP:   if (bus.rsp_ready_i) begin
                pop_c   = last_q;
                hit_d   = 1'b0;
                idx_d   = '0;
                tmo_d   = 1'b0;
                state_d = last_q ? IDLE : READY;
              end
      default: state_d = IDLE;
    endcase
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pstart_q     <= '0;
      overflow_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      tag_q        <= '0;
      last_q       <= 1'b0;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      cam_search_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cam_start_q  <= '0;
      cam_end_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pstart_q     <= pstart_d;
      overflow_q   <= overflow_d;
      proto_err_q  <= proto_err_d;
      tag_q        <= tag_d;
      last_q       <= last_d;
      hit_q        <= hit_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == READY);
      cam_search_q <= (state_d == SEARCH);
      rsp_valid_q  <= (state_d == RESP);
      cam_start_q  <= (state_d != IDLE) ? head[DESC_W-1:ADDR_WIDTH] : '0;
      cam_end_q    <= (state_d != IDLE) ? head[ADDR_WIDTH-1:0] : '0;
    end
  end

  assign bus.req_ready_o       = req_ready_q;
  assign bus.cam_search_o      = cam_search_q;
  assign bus.cam_search_data_o = tag_q;
  assign bus.cam_start_o       = cam_start_q;
  assign bus.cam_end_o         = cam_end_q;
  assign bus.rsp_valid_o       = rsp_valid_q;
  assign bus.rsp_hit_o         = hit_q;
  assign bus.rsp_index_o       = idx_q;
  assign bus.rsp_timeout_o     = tmo_q;
  assign msg_avail_o           = (fifo_count != '0);
  assign desc_full_o           = fifo_full;
  assign overflow_o            = overflow_q;
  assign proto_err_o           = proto_err_q;

endmodule

// File: tb/tb_cam_msg_sched.sv
// Directed bench for cam_msg_sched with hand-computed expectations.
module tb_cam_msg_sched;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       store_start_i = 1'b0;
  logic       store_end_i = 1'b0;
  logic [4:0] start_addr_i = '0;
  logic [4:0] end_addr_i = '0;
  logic       msg_avail_o, desc_full_o, overflow_o, proto_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  cam_msg_sched_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  cam_msg_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DESC_DEPTH(4), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .store_start_i (store_start_i),
    .store_end_i   (store_end_i),
    .start_addr_i  (start_addr_i),
    .end_addr_i    (end_addr_i),
    .bus           (bus),
    .msg_avail_o   (msg_avail_o),
    .desc_full_o   (desc_full_o),
    .overflow_o    (overflow_o),
    .proto_err_o   (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input logic [4:0] s, input logic [4:0] e);
    store_start_i = 1'b1; start_addr_i = s;
    tick();
    store_start_i = 1'b0;
    store_end_i = 1'b1; end_addr_i = e;
    tick();
    store_end_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  32'(bus.req_ready_o), 32'd0);
    check({tag, "_search"}, 32'(bus.cam_search_o), 32'd0);
    check({tag, "_sdata"},  bus.cam_search_data_o, 32'd0);
    check({tag, "_cstart"}, 32'(bus.cam_start_o), 32'd0);
    check({tag, "_cend"},   32'(bus.cam_end_o), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "_rhit"},   32'(bus.rsp_hit_o), 32'd0);
    check({tag, "_ridx"},   32'(bus.rsp_index_o), 32'd0);
    check({tag, "_rtmo"},   32'(bus.rsp_timeout_o), 32'd0);
    check({tag, "_avail"},  32'(msg_avail_o), 32'd0);
    check({tag, "_full"},   32'(desc_full_o), 32'd0);
    check({tag, "_ovf"},    32'(overflow_o), 32'd0);
    check({tag, "_perr"},   32'(proto_err_o), 32'd0);
  endtask

  // Called in READY; returns right after the response is accepted.
  task automatic do_lookup(input logic [31:0] tag, input logic last,
                           input logic [4:0] exp_s, input logic [4:0] exp_e,
                           input logic hit, input logic [4:0] idx);
    check("lk_ready", 32'(bus.req_ready_o), 32'd1);
    check("lk_win_s", 32'(bus.cam_start_o), 32'(exp_s));
    check("lk_win_e", 32'(bus.cam_end_o), 32'(exp_e));
    bus.req_valid_i = 1'b1; bus.req_tag_i = tag; bus.req_last_i = last;
    tick();
    bus.req_valid_i = 1'b0;
    check("lk_search", 32'(bus.cam_search_o), 32'd1);
    check("lk_sdata", bus.cam_search_data_o, tag);
    check("lk_ready_low", 32'(bus.req_ready_o), 32'd0);
    tick();
    check("lk_search_1cyc", 32'(bus.cam_search_o), 32'd0);
    check("lk_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
    bus.cam_done_i = 1'b1; bus.cam_hit_i = hit; bus.cam_index_i = idx;
    tick();
    bus.cam_done_i = 1'b0; bus.cam_hit_i = 1'b0; bus.cam_index_i = '0;
    check("lk_rvalid", 32'(bus.rsp_valid_o), 32'd1);
    check("lk_rhit", 32'(bus.rsp_hit_o), 32'(hit));
    check("lk_ridx", 32'(bus.rsp_index_o), 32'(idx));
    check("lk_rtmo", 32'(bus.rsp_timeout_o), 32'd0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("lk_rvalid_drop", 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_tag_i = '0; bus.req_last_i = 1'b0;
    bus.cam_done_i = 1'b0; bus.cam_hit_i = 1'b0; bus.cam_index_i = '0;
    bus.rsp_ready_i = 1'b0;

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    rst = 1'b0;
    tick();
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Basic lookup: window 3..9, hit at index 5, 3-cycle latency
    push_msg(5'd3, 5'd9);
    check("b_avail", 32'(msg_avail_o), 32'd1);
    tick();
    do_lookup(32'h38, 1'b1, 5'd3, 5'd9, 1'b1, 5'd5);
    check("b_empty", 32'(msg_avail_o), 32'd0);
    check("b_cstart_idle", 32'(bus.cam_start_o), 32'd0);

    // End without start: protocol error, nothing queued
    store_end_i = 1'b1; end_addr_i = 5'd4;
    tick();
    store_end_i = 1'b0;
    check("perr_set", 32'(proto_err_o), 32'd1);
    tick();
    check("perr_no_push", 32'(msg_avail_o), 32'd0);
    check("perr_idle", 32'(bus.req_ready_o), 32'd0);

    // Wrapping window 30..2, lookup that times out
    push_msg(5'd30, 5'd2);
    tick();
    check("wrap_s", 32'(bus.cam_start_o), 32'd30);
    check("wrap_e", 32'(bus.cam_end_o), 32'd2);
    bus.req_valid_i = 1'b1; bus.req_tag_i = 32'hABCD; bus.req_last_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("tmo_in_wait", 32'(dut.state_q), 32'(WAIT));
    for (int i = 0; i < 15; i++) tick();
    check("tmo_not_early", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    check("tmo_rvalid", 32'(bus.rsp_valid_o), 32'd1);
    check("tmo_flag", 32'(bus.rsp_timeout_o), 32'd1);
    check("tmo_hit", 32'(bus.rsp_hit_o), 32'd0);
    bus.cam_done_i = 1'b1; bus.cam_hit_i = 1'b1; bus.cam_index_i = 5'd7;
    tick();
    bus.cam_done_i = 1'b0; bus.cam_hit_i = 1'b0; bus.cam_index_i = '0;
    check("late_done_hit", 32'(bus.rsp_hit_o), 32'd0);
    check("late_done_idx", 32'(bus.rsp_index_o), 32'd0);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("tmo_popped", 32'(msg_avail_o), 32'd0);

    // Five messages into a four-deep queue
    for (int i = 0; i < 5; i++) begin
      push_msg(5'(i + 1), 5'(i + 10));
      if (i == 3) begin
        check("q_full4", 32'(desc_full_o), 32'd1);
        check("q_no_ovf4", 32'(overflow_o), 32'd0);
      end
      if (i == 4) begin
        check("q_full5", 32'(desc_full_o), 32'd1);
        check("q_ovf5", 32'(overflow_o), 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      do_lookup(32'h100 + 32'(i), 1'b1, 5'(i + 1), 5'(i + 10), 1'(i), 5'(i + 2));
      if (i == 0) check("q_not_full", 32'(desc_full_o), 32'd0);
      tick();
    end
    check("q_drained", 32'(msg_avail_o), 32'd0);
    check("q_ovf_sticky", 32'(overflow_o), 32'd1);

    // Same-cycle end+start, then multi-lookup message
    store_start_i = 1'b1; start_addr_i = 5'd7;
    tick();
    store_end_i = 1'b1; end_addr_i = 5'd8; start_addr_i = 5'd11;
    tick();
    store_start_i = 1'b0; end_addr_i = 5'd12;
    tick();
    store_end_i = 1'b0;
    tick();
    do_lookup(32'h77, 1'b0, 5'd7, 5'd8, 1'b1, 5'd1);
    check("ml_back_ready", 32'(bus.req_ready_o), 32'd1);
    do_lookup(32'h78, 1'b1, 5'd7, 5'd8, 1'b0, 5'd0);
    tick();
    do_lookup(32'h79, 1'b1, 5'd11, 5'd12, 1'b1, 5'd3);
    tick();
    check("ml_drained", 32'(msg_avail_o), 32'd0);

    // Response stall then reset during WAIT
    push_msg(5'd5, 5'd6);
    tick();
    bus.req_valid_i = 1'b1; bus.req_tag_i = 32'h11; bus.req_last_i = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.cam_done_i = 1'b1; bus.cam_hit_i = 1'b1; bus.cam_index_i = 5'd9;
    tick();
    bus.cam_done_i = 1'b0; bus.cam_hit_i = 1'b0; bus.cam_index_i = '0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("stall_hit", 32'(bus.rsp_hit_o), 32'd1);
      check("stall_idx", 32'(bus.rsp_index_o), 32'd9);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check("stall_ready", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1; bus.req_tag_i = 32'h22; bus.req_last_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    check("pre_rst_wait", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    check_all_zero("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
